zeroriscy_instr_aligner: RTL and testbench
==========================================

ZERORISCY_INSTR_ALIGNER -- requirements
Module: zeroriscy_instr_aligner

Interface
REQ-001 Parameter RVC_EN, default 1, SHALL enable 16-bit compressed instruction alignment; 0 = every fetched word is one 32-bit instruction.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 fetch_valid_i  input  1  SHALL mean that the word from the prefetch buffer is valid.
REQ-005 fetch_rdata_i  input  32  SHALL carry the fetched instruction word.
REQ-006 fetch_addr_i  input  32  SHALL carry the address of the fetched word.
REQ-007 fetch_ready_o  output  1  SHALL signal that the current fetch word is consumed this cycle.
REQ-008 branch_i  input  1  SHALL signal a redirect; same cycle as the prefetch buffer's branch.
REQ-009 branch_addr_i  input  32  SHALL carry the redirect target; only bit 1 is used.
REQ-010 instr_valid_o  output  1  SHALL mean that an aligned instruction is presented.
REQ-011 instr_rdata_o  output  32  SHALL carry the instruction; compressed instructions are zero-extended to {16'h0, hw}.
REQ-012 instr_addr_o  output  32  SHALL carry the instruction's byte address.
REQ-013 instr_compressed_o  output  1  SHALL be 1 when the presented instruction is 16-bit.
REQ-014 instr_ready_i  input  1  SHALL mean that the decode stage accepts the instruction; transfer = valid & ready.

Function
REQ-015 A halfword hw SHALL be compressed iff RVC_EN=1 and hw[1:0] != 2'b11.
REQ-016 FSM states SHALL be ALIGNED, HALF and SKIP_LO. Registers SHALL be hw_q[15:0] (held upper halfword) and hw_addr_q[31:0].
REQ-017 In ALIGNED, the output SHALL be gated on fetch_valid_i: instr_addr_o=fetch_addr_i.
- rdata[15:0] compressed: output it; on transfer, fetch_ready_o=1, hw_q<=rdata[31:16], hw_addr_q<={fetch_addr_i[31:2],2'b10}, and the FSM goes to HALF.
- Otherwise: output the full word; on transfer, fetch_ready_o=1 and the FSM stays in ALIGNED.
REQ-018 In HALF with hw_q compressed: instr_valid_o=1 regardless of fetch_valid_i; output {16'h0,hw_q} at hw_addr_q; fetch_ready_o=0; on transfer the FSM goes to ALIGNED.
REQ-019 In HALF with hw_q 32-bit: instr_valid_o=fetch_valid_i; output {fetch_rdata_i[15:0],hw_q} at hw_addr_q.
- On transfer: fetch_ready_o=1, hw_q<=fetch_rdata_i[31:16], hw_addr_q<={fetch_addr_i[31:2],2'b10}, and the FSM stays in HALF.
REQ-020 In SKIP_LO: instr_valid_o=0. When fetch_valid_i=1: fetch_ready_o=1, hw_q<=fetch_rdata_i[31:16], hw_addr_q<={fetch_addr_i[31:2],2'b10}, and the FSM goes to HALF; this costs a one-cycle bubble.
REQ-021 fetch_ready_o SHALL never be 1 while fetch_valid_i=0, and SHALL never be 1 without a transfer except in SKIP_LO.
REQ-022 branch_i=1 SHALL take priority over all other events:
- forces instr_valid_o=0 and fetch_ready_o=0 that cycle;
- next state = SKIP_LO if RVC_EN=1 and branch_addr_i[1]=1, else ALIGNED;
- a held halfword is discarded.
REQ-023 While instr_valid_o=1 and instr_ready_i=0, all outputs SHALL remain stable provided the inputs are stable; no register SHALL update.
REQ-024 With RVC_EN=0, the FSM SHALL remain in ALIGNED and instr_compressed_o SHALL be 0.
REQ-025 Address arithmetic SHALL be 32-bit; the address of the last halfword at 32'hFFFF_FFFE SHALL need no carry handling, because it is formed by concatenation.
REQ-026 The design SHALL be deadlock-free: from HALF with a compressed hw_q, progress SHALL require only instr_ready_i.

Reset
REQ-027 While rst=1:
- state=ALIGNED, hw_q=16'h0, hw_addr_q=32'h0;
- instr_valid_o=0, fetch_ready_o=0, instr_compressed_o=0, instr_rdata_o=0, instr_addr_o=0.
REQ-028 Reset asserted mid-operation SHALL discard any held halfword immediately, with no transfer that cycle.
REQ-029 After rst deasserts, the first instruction SHALL be taken from bits [15:0] of the next valid fetch word.

Verification
REQ-030 ALIGNED, word 32'h00A00093 @0x100, ready=1 -> valid, rdata=32'h00A00093, addr=0x100, compressed=0, fetch_ready=1.
REQ-031 Word 32'h4505_4485 @0x200 (two compressed halfwords), ready=1:
- cycle 1 -> rdata=32'h0000_4485, addr=0x200, fetch_ready=1;
- cycle 2 -> rdata=32'h0000_4505, addr=0x202, fetch_ready=0.
REQ-032 Words 32'h0093_4485 @0x300 then 32'h1111_00A0 @0x304:
- 0x0093 has bits [1:0]=11, so the instruction at 0x302 is 32-bit and straddles the two words;
- the straddled output SHALL be rdata=32'h00A0_0093, addr=0x302, compressed=0.
REQ-033 branch_i=1 with branch_addr_i=0x402, then word 32'h4485_FFFF @0x400 -> one bubble cycle, then rdata=32'h0000_4485, addr=0x402.
REQ-034 Stall: instr_ready_i=0 for 3 cycles in HALF -> outputs constant and hw_q unchanged; branch_i during the stall -> valid=0 next cycle, held halfword dropped.
REQ-035 rst pulsed while in HALF -> instr_valid_o=0 immediately; the next fetch word is decoded from bits [15:0].

Source files
------------

// File: rtl/zeroriscy_instr_aligner_if.sv
// Handshake bundle between prefetch buffer, instruction aligner and decode stage.
// The aligner connects through the slave modport; the fetch/decode side uses master.
interface zeroriscy_instr_aligner_if;
   logic        fetch_valid_i;
   logic [31:0] fetch_rdata_i;
   logic [31:0] fetch_addr_i;
   logic        fetch_ready_o;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        instr_valid_o;
   logic [31:0] instr_rdata_o;
   logic [31:0] instr_addr_o;
   logic        instr_compressed_o;
   logic        instr_ready_i;

   modport master (
      output fetch_valid_i, fetch_rdata_i, fetch_addr_i, branch_i, branch_addr_i, instr_ready_i,
      input  fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o, instr_compressed_o
   );

   modport slave (
      input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, branch_i, branch_addr_i, instr_ready_i,
      output fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o, instr_compressed_o
   );
endinterface

// File: rtl/zeroriscy_instr_aligner.sv
// Splits 32-bit fetch words into aligned 16/32-bit instructions, holding the upper
// halfword of a word across cycles so 32-bit instructions may straddle two words.
module zeroriscy_instr_aligner #(
   parameter int RVC_EN = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   zeroriscy_instr_aligner_if.slave       bus
);

   typedef enum logic [1:0] {
      ALIGNED = 2'd0,
      HALF    = 2'd1,
      SKIP_LO = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] hw_q, hw_d;
   logic [31:0] hw_addr_q, hw_addr_d;

   logic        out_valid;
   logic [31:0] out_rdata;
   logic [31:0] out_addr;
   logic        out_compressed;
   logic        out_fetch_ready;

   logic [15:0] fetch_lo;
   logic [15:0] fetch_hi;
   logic [31:0] fetch_hi_addr;

   function automatic logic is_compressed(input logic [15:0] hw);
      return (RVC_EN != 0) && (hw[1:0] != 2'b11);
   endfunction

   assign fetch_lo      = bus.fetch_rdata_i[15:0];
   assign fetch_hi      = bus.fetch_rdata_i[31:16];
   // Upper-halfword address by concatenation, so the top of memory never carries.
   assign fetch_hi_addr = {bus.fetch_addr_i[31:2], 2'b10};

   always_comb begin
      state_d         = state_q;
      hw_d            = hw_q;
      hw_addr_d       = hw_addr_q;
      out_valid       = 1'b0;
      out_rdata       = bus.fetch_rdata_i;
      out_addr        = bus.fetch_addr_i;
      out_compressed  = 1'b0;
      out_fetch_ready = 1'b0;

      unique case (state_q)
         ALIGNED: begin
            out_valid = bus.fetch_valid_i;
            if (is_compressed(fetch_lo)) begin
               out_rdata      = {16'h0, fetch_lo};
               out_compressed = 1'b1;
               if (bus.fetch_valid_i && bus.instr_ready_i) begin
                  out_fetch_ready = 1'b1;
                  hw_d            = fetch_hi;
                  hw_addr_d       = fetch_hi_addr;
                  state_d         = HALF;
               end
            end else begin
               out_fetch_ready = bus.fetch_valid_i && bus.instr_ready_i;
            end
         end

         HALF: begin
            out_addr = hw_addr_q;
            if (is_compressed(hw_q)) begin
               // Held compressed halfword needs no fetch data, so decode alone drains it.
               out_valid      = 1'b1;
               out_rdata      = {16'h0, hw_q};
               out_compressed = 1'b1;
               if (bus.instr_ready_i) begin
                  state_d = ALIGNED;
               end
            end else begin
               out_valid = bus.fetch_valid_i;
               out_rdata = {fetch_lo, hw_q};
               if (bus.fetch_valid_i && bus.instr_ready_i) begin
                  out_fetch_ready = 1'b1;
                  hw_d            = fetch_hi;
                  hw_addr_d       = fetch_hi_addr;
               end
            end
         end

         SKIP_LO: begin
            if (bus.fetch_valid_i) begin
               out_fetch_ready = 1'b1;
               hw_d            = fetch_hi;
               hw_addr_d       = fetch_hi_addr;
               state_d         = HALF;
            end
         end

         default: begin
            state_d = ALIGNED;
         end
      endcase

      // A redirect wins over everything: no transfer, held halfword abandoned.
      if (bus.branch_i) begin
         out_valid       = 1'b0;
         out_fetch_ready = 1'b0;
         hw_d            = hw_q;
         hw_addr_d       = hw_addr_q;
         state_d         = ((RVC_EN != 0) && bus.branch_addr_i[1]) ? SKIP_LO : ALIGNED;
      end

      if (rst) begin
         out_valid       = 1'b0;
         out_rdata       = 32'h0;
         out_addr        = 32'h0;
         out_compressed  = 1'b0;
         out_fetch_ready = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ALIGNED;
         hw_q      <= 16'h0;
         hw_addr_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         hw_q      <= hw_d;
         hw_addr_q <= hw_addr_d;
      end
   end

   assign bus.instr_valid_o      = out_valid;
   assign bus.instr_rdata_o      = out_rdata;
   assign bus.instr_addr_o       = out_addr;
   assign bus.instr_compressed_o = out_compressed;
   assign bus.fetch_ready_o      = out_fetch_ready;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.fetch_addr_i[1:0], bus.branch_addr_i[31:2], bus.branch_addr_i[0]};

endmodule

// File: tb/tb_zeroriscy_instr_aligner.sv
// Randomized scoreboard bench: a halfword-walking program model predicts the aligned
// instruction stream for each fetch segment; monitors compare every decode transfer.
module tb_zeroriscy_instr_aligner;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        comp;
   } exp_t;

   logic clk;
   logic rst;

   zeroriscy_instr_aligner_if bus();
   zeroriscy_instr_aligner_if bus32();

   zeroriscy_instr_aligner #(.RVC_EN(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   zeroriscy_instr_aligner #(.RVC_EN(0)) u_dut32 (
      .clk (clk),
      .rst (rst),
      .bus (bus32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   exp_t        exp_q[$];
   exp_t        exp32_q[$];
   logic [31:0] mem [64];
   logic        skip_exp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[7:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // Reference: walk the program halfword by halfword from pc0.
   function automatic void build(input logic [31:0] pc0, input int n);
      logic [31:0] pc;
      logic [15:0] lo;
      exp_t        e;
      pc = pc0;
      for (int i = 0; i < n; i++) begin
         lo = mem_hw(pc);
         e.addr = pc;
         if (lo[1:0] != 2'b11) begin
            e.rdata = {16'h0, lo};
            e.comp  = 1'b1;
            pc      = pc + 32'd2;
         end else begin
            e.rdata = {mem_hw(pc + 32'd2), lo};
            e.comp  = 1'b0;
            pc      = pc + 32'd4;
         end
         exp_q.push_back(e);
      end
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
      return w;
   endfunction

   function automatic void rand_mem();
      for (int i = 0; i < 64; i++) mem[i] = rand_word();
   endfunction

   task automatic reset_checks();
      check("rst_instr_valid", {31'h0, bus.instr_valid_o}, 32'h0);
      check("rst_fetch_ready", {31'h0, bus.fetch_ready_o}, 32'h0);
      check("rst_compressed",  {31'h0, bus.instr_compressed_o}, 32'h0);
      check("rst_rdata",       bus.instr_rdata_o, 32'h0);
      check("rst_addr",        bus.instr_addr_o, 32'h0);
   endtask

   // Monitor for the compressed-capable instance
   initial begin
      logic stall_prev;
      exp_t prev;
      exp_t e;
      stall_prev = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (bus.fetch_ready_o)
               check("fetch_ready_needs_valid", {31'h0, bus.fetch_valid_i}, 32'h1);
            if (bus.fetch_ready_o && !(bus.instr_valid_o && bus.instr_ready_i))
               check("fetch_ready_only_xfer_or_skip", {31'h0, skip_exp}, 32'h1);
            if (bus.branch_i)
               check("branch_kills_valid", {31'h0, bus.instr_valid_o}, 32'h0);
            else if (stall_prev) begin
               check("stall_valid", {31'h0, bus.instr_valid_o}, 32'h1);
               check("stall_rdata", bus.instr_rdata_o, prev.rdata);
               check("stall_addr",  bus.instr_addr_o,  prev.addr);
            end
            if (bus.instr_valid_o && bus.instr_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_instr: got %h @%h, expected none", bus.instr_rdata_o, bus.instr_addr_o);
               end else begin
                  e = exp_q.pop_front();
                  check("instr_rdata", bus.instr_rdata_o, e.rdata);
                  check("instr_addr",  bus.instr_addr_o,  e.addr);
                  check("instr_compressed", {31'h0, bus.instr_compressed_o}, {31'h0, e.comp});
               end
            end
            stall_prev = bus.instr_valid_o && !bus.instr_ready_i;
            prev.rdata = bus.instr_rdata_o;
            prev.addr  = bus.instr_addr_o;
            prev.comp  = bus.instr_compressed_o;
         end
      end
   end

   // Monitor for the 32-bit-only instance
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("r32_valid", {31'h0, bus32.instr_valid_o}, {31'h0, bus32.fetch_valid_i});
            check("r32_fetch_ready", {31'h0, bus32.fetch_ready_o},
                  {31'h0, bus32.instr_valid_o & bus32.instr_ready_i});
            if (bus32.instr_valid_o && bus32.instr_ready_i) begin
               if (exp32_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL r32_unexpected: got %h, expected none", bus32.instr_rdata_o);
               end else begin
                  e = exp32_q.pop_front();
                  check("r32_rdata", bus32.instr_rdata_o, e.rdata);
                  check("r32_addr",  bus32.instr_addr_o,  e.addr);
                  check("r32_compressed", {31'h0, bus32.instr_compressed_o}, 32'h0);
               end
            end
         end
      end
   end

   localparam int NCYC = 4000;

   logic [31:0] dir_tgt [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0402};
   logic [31:0] dir_w0  [4] = '{32'h00A0_0093, 32'h4505_4485, 32'h0093_4485, 32'h4485_FFFF};
   logic [31:0] dir_w1  [4] = '{32'h0000_0001, 32'h0000_0001, 32'h1111_00A0, 32'h0000_0001};
   int          dir_n   [4] = '{1, 2, 2, 1};

   logic [31:0] fa;
   logic        fv;
   int          age;
   int          dseg;

   task automatic new_segment(input logic [31:0] tgt, input int n);
      exp_q.delete();
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = tgt;
      fa       = {tgt[31:2], 2'b00};
      fv       = 1'b0;
      skip_exp = tgt[1];
      age      = 0;
      build(tgt, n);
   endtask

   task automatic next_segment();
      logic [31:0] tgt;
      logic [5:0]  idx;
      rand_mem();
      if (dseg < 4) begin
         idx      = dir_tgt[dseg][7:2];
         mem[idx] = dir_w0[dseg];
         idx      = idx + 6'd1;
         mem[idx] = dir_w1[dseg];
         new_segment(dir_tgt[dseg], dir_n[dseg]);
         dseg++;
      end else begin
         tgt = $urandom;
         tgt[0] = 1'b0;
         if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF0 | (32'($urandom_range(7, 0)) << 1);
         new_segment(tgt, $urandom_range(12, 1));
      end
   endtask

   task automatic drive_main();
      logic fr_s;
      logic rst_chk;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         fr_s = bus.fetch_ready_o;
         @(posedge clk);
         #1;
         rst_chk      = 1'b0;
         bus.branch_i = 1'b0;
         if (rst) rst = 1'b0;
         if (fr_s) begin
            fa       = fa + 32'd4;
            fv       = 1'b0;
            skip_exp = 1'b0;
         end
         age = (exp_q.size() != 0) ? age + 1 : 0;
         if (age > 100) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d instructions still pending, expected 0", exp_q.size());
            next_segment();
         end else if (exp_q.size() == 0) begin
            next_segment();
         end else if (dseg >= 4 && $urandom_range(99, 0) < 2) begin
            next_segment();
         end else if (dseg >= 4 && $urandom_range(149, 0) == 0) begin
            rst = 1'b1;
            rst_chk  = 1'b1;
            skip_exp = 1'b0;
            exp_q.delete();
            rand_mem();
            fa  = {$urandom_range(32'hFFFF_FFFF, 0)} & 32'hFFFF_FFFC;
            fv  = 1'b1;
            age = 0;
            build(fa, $urandom_range(10, 1));
         end
         if (!fv) fv = ($urandom_range(3, 0) != 0);
         bus.fetch_valid_i = fv;
         bus.fetch_rdata_i = mem[fa[7:2]];
         bus.fetch_addr_i  = fa;
         bus.instr_ready_i = (exp_q.size() != 0) && ($urandom_range(3, 0) != 0);
         if (rst_chk) begin
            #1;
            reset_checks();
         end
      end
   endtask

   task automatic drive_32();
      logic        fr_s;
      logic        v32;
      logic [31:0] a32;
      logic [31:0] w32;
      exp_t        e;
      v32 = 1'b0;
      a32 = 32'h0000_1000;
      w32 = 32'h0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         fr_s = bus32.fetch_ready_o;
         @(posedge clk);
         #1;
         if (fr_s) begin
            a32 = a32 + 32'd4;
            v32 = 1'b0;
         end
         if (!v32 && $urandom_range(1, 0) == 1) begin
            v32     = 1'b1;
            w32     = $urandom;
            e.rdata = w32;
            e.addr  = a32;
            e.comp  = 1'b0;
            exp32_q.push_back(e);
         end
         bus32.fetch_valid_i = v32;
         bus32.fetch_rdata_i = w32;
         bus32.fetch_addr_i  = a32;
         bus32.instr_ready_i = ($urandom_range(3, 0) != 0);
      end
   endtask

   initial begin
      rst  = 1'b1;
      dseg = 0;
      age  = 0;
      rand_mem();
      fa = 32'h0000_0000;
      fv = 1'b1;
      bus.fetch_valid_i   = 1'b1;
      bus.fetch_rdata_i   = mem[0];
      bus.fetch_addr_i    = fa;
      bus.branch_i        = 1'b0;
      bus.branch_addr_i   = 32'h0;
      bus.instr_ready_i   = 1'b1;
      bus32.fetch_valid_i = 1'b0;
      bus32.fetch_rdata_i = 32'h0;
      bus32.fetch_addr_i  = 32'h0;
      bus32.branch_i      = 1'b0;
      bus32.branch_addr_i = 32'h0;
      bus32.instr_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks();
      bus.instr_ready_i = 1'b0;
      rst = 1'b0;
      fork
         drive_main();
         drive_32();
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
